bus_decoder_ws: RTL and testbench

BUS_DECODER_WS -- requirements
Module: bus_decoder_ws

---
 rtl/bus_decoder_ws_pkg.sv | 22 ++
 rtl/bus_decoder_ws_match.sv | 51 +++++
 rtl/bus_decoder_ws.sv | 161 ++++++++++++++++
 tb/tb_bus_decoder_ws.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_decoder_ws_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_decoder_ws_pkg
// Brief    : Shared types and constants for the wait-state bus decoder.
// Revision : 1.0 - initial release
// ============================================================================
package bus_decoder_ws_pkg;

    localparam int C_SHIFT_W             = 5;
    localparam int C_DEFAULT_BERR_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ACK     = 3'd3,
        ST_NOMATCH = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_decoder_ws_match.sv
`default_nettype none
// ============================================================================
// Module   : bus_region_match
// Brief    : Combinational priority region matcher; lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module bus_region_match
    import bus_decoder_ws_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4
) (
    input  logic [ADDR_W-1:0]              addr,
    input  logic [NUM_REGIONS*ADDR_W-1:0]  rgn_base,
    input  logic [NUM_REGIONS*C_SHIFT_W-1:0] rgn_shift,
    input  logic [NUM_REGIONS*WAIT_W-1:0]  rgn_wait,
    input  logic [NUM_REGIONS-1:0]         rgn_en,
    output logic [NUM_REGIONS-1:0]         match,
    output logic                           valid,
    output logic [WAIT_W-1:0]              wait_cnt
);

    logic [NUM_REGIONS-1:0] w_hit;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        logic [C_SHIFT_W-1:0] w_sh;
        logic [ADDR_W-1:0]    w_mask;

        assign w_sh   = rgn_shift[i*C_SHIFT_W +: C_SHIFT_W];
        // A shift of ADDR_W or more ignores every bit, so the region matches all.
        assign w_mask = (32'(w_sh) >= ADDR_W) ? '0 : ({ADDR_W{1'b1}} << w_sh);
        assign w_hit[i] = rgn_en[i] &&
                          (((addr ^ rgn_base[i*ADDR_W +: ADDR_W]) & w_mask) == '0);
    end

    always_comb begin
        match    = '0;
        valid    = 1'b0;
        wait_cnt = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_hit[i] && !valid) begin
                match[i] = 1'b1;
                valid    = 1'b1;
                wait_cnt = rgn_wait[i*WAIT_W +: WAIT_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_decoder_ws.sv
`default_nettype none
// ============================================================================
// Module   : bus_decoder_ws
// Brief    : Region address decoder with per-region wait states and DTACK.
//            Define BUS_DECODER_BERR_EN to enable the no-match bus-error timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_decoder_ws
    import bus_decoder_ws_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4,
    parameter int BERR_CYCLES = C_DEFAULT_BERR_CYCLES
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [ADDR_W-1:0]                addr,
    input  logic                             as_n,
    input  logic [NUM_REGIONS*ADDR_W-1:0]    rgn_base,
    input  logic [NUM_REGIONS*C_SHIFT_W-1:0] rgn_shift,
    input  logic [NUM_REGIONS*WAIT_W-1:0]    rgn_wait,
    input  logic [NUM_REGIONS-1:0]           rgn_en,
    output logic [NUM_REGIONS-1:0]           cs,
    output logic                             dtack_n,
    output logic                             berr_n,
    output logic                             busy
);

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0]                r_addr;
    logic [NUM_REGIONS*ADDR_W-1:0]    r_base;
    logic [NUM_REGIONS*C_SHIFT_W-1:0] r_shift;
    logic [NUM_REGIONS*WAIT_W-1:0]    r_wait;
    logic [NUM_REGIONS-1:0]           r_en;
    logic [NUM_REGIONS-1:0]           r_cs;
    logic [WAIT_W-1:0]                r_wcnt;

    logic [NUM_REGIONS-1:0] w_match;
    logic                   w_valid;
    logic [WAIT_W-1:0]      w_wait;

    // Matching runs on the latched snapshot so later bus changes cannot leak in.
    bus_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .WAIT_W      (WAIT_W)
    ) u_match (
        .addr      (r_addr),
        .rgn_base  (r_base),
        .rgn_shift (r_shift),
        .rgn_wait  (r_wait),
        .rgn_en    (r_en),
        .match     (w_match),
        .valid     (w_valid),
        .wait_cnt  (w_wait)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!as_n) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (as_n)         w_next = ST_RELEASE;
                else if (w_valid) w_next = ST_WAIT;
                else              w_next = ST_NOMATCH;
            end
            ST_WAIT: begin
                if (as_n)              w_next = ST_RELEASE;
                else if (r_wcnt == '0) w_next = ST_ACK;
            end
            ST_ACK: begin
                if (as_n) w_next = ST_RELEASE;
            end
            ST_NOMATCH: begin
                if (as_n) w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_base  <= '0;
            r_shift <= '0;
            r_wait  <= '0;
            r_en    <= '0;
            r_cs    <= '0;
            r_wcnt  <= '0;
        end else begin
            if (r_state == ST_IDLE && !as_n) begin
                r_addr  <= addr;
                r_base  <= rgn_base;
                r_shift <= rgn_shift;
                r_wait  <= rgn_wait;
                r_en    <= rgn_en;
            end
            if (r_state == ST_DECODE) begin
                r_cs   <= w_match;
                r_wcnt <= w_wait;
            end else if (r_state == ST_WAIT && r_wcnt != '0) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
            // Any path into RELEASE drops the selects, including aborts from DECODE.
            if (w_next == ST_RELEASE) begin
                r_cs   <= '0;
                r_wcnt <= '0;
            end
        end
    end

`ifdef BUS_DECODER_BERR_EN
    localparam int TMO_W = $clog2(BERR_CYCLES);

    logic [TMO_W-1:0] r_tmo;
    logic             r_berr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo  <= '0;
            r_berr <= 1'b0;
        end else if (r_state == ST_NOMATCH && !as_n) begin
            if (!r_berr) begin
                if (r_tmo == TMO_W'(BERR_CYCLES - 1)) r_berr <= 1'b1;
                else                                   r_tmo  <= r_tmo + 1'b1;
            end
        end else begin
            r_tmo  <= '0;
            r_berr <= 1'b0;
        end
    end

    assign berr_n = ~r_berr;
`else
    assign berr_n = 1'b1;
`endif

    assign cs      = r_cs;
    assign dtack_n = (r_state != ST_ACK);
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_decoder_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_decoder_ws
// Brief    : Self-checking bench for bus_decoder_ws against a region-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_decoder_ws;

    localparam int NR = 16;
    localparam int AW = 24;
    localparam int WW = 4;
    localparam int BC = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [AW-1:0]    addr;
    logic             as_n;
    logic [NR*AW-1:0] rgn_base;
    logic [NR*5-1:0]  rgn_shift;
    logic [NR*WW-1:0] rgn_wait;
    logic [NR-1:0]    rgn_en;
    logic [NR-1:0]    cs;
    logic             dtack_n;
    logic             berr_n;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference region table.
    logic [AW-1:0] base_a  [NR];
    int            shift_a [NR];
    int            wait_a  [NR];
    bit            en_a    [NR];

    bus_decoder_ws #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .WAIT_W      (WW),
        .BERR_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .as_n      (as_n),
        .rgn_base  (rgn_base),
        .rgn_shift (rgn_shift),
        .rgn_wait  (rgn_wait),
        .rgn_en    (rgn_en),
        .cs        (cs),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_table();
        for (int i = 0; i < NR; i++) begin
            base_a[i] = '0; shift_a[i] = 0; wait_a[i] = 0; en_a[i] = 1'b0;
        end
    endtask

    task automatic pack_table();
        for (int i = 0; i < NR; i++) begin
            rgn_base[i*AW +: AW] = base_a[i];
            rgn_shift[i*5 +: 5]  = 5'(shift_a[i]);
            rgn_wait[i*WW +: WW] = WW'(wait_a[i]);
            rgn_en[i]            = en_a[i];
        end
    endtask

    // First enabled region whose unignored address bits agree wins.
    function automatic logic [NR-1:0] model_cs(input logic [AW-1:0] a, output int w);
        w = 0;
        for (int i = 0; i < NR; i++) begin
            if (en_a[i] && (shift_a[i] >= AW || (a >> shift_a[i]) == (base_a[i] >> shift_a[i]))) begin
                w = wait_a[i];
                return NR'(1) << i;
            end
        end
        return '0;
    endfunction

    // Drives a strobe and reports edge numbers (edge 1 = first sampling as_n low).
    task automatic run_cycle(input logic [AW-1:0] a, input int budget, input bit scramble,
                             output int ack_edge, output int berr_edge,
                             output logic [NR-1:0] cs2, output logic [NR-1:0] cs_ack);
        ack_edge = -1; berr_edge = -1; cs2 = '0; cs_ack = '0;
        @(negedge clk);
        addr = a;
        as_n = 1'b0;
        for (int e = 1; e <= budget; e++) begin
            @(negedge clk);
            if (e == 2) cs2 = cs;
            if (ack_edge < 0 && dtack_n == 1'b0) begin ack_edge = e; cs_ack = cs; end
            if (berr_edge < 0 && berr_n == 1'b0) berr_edge = e;
            if (e == 1 && scramble) begin
                addr = AW'($urandom);
                for (int i = 0; i < NR; i++) begin
                    rgn_base[i*AW +: AW] = AW'($urandom);
                    rgn_wait[i*WW +: WW] = WW'($urandom);
                end
                rgn_en = ~rgn_en;
            end
            if (ack_edge >= 0 || berr_edge >= 0) break;
        end
    endtask

    task automatic release_cycle(output logic [NR-1:0] cs_rel, output logic dt_rel,
                                 output logic be_rel, output logic busy_idle);
        as_n = 1'b1;
        pack_table();
        @(negedge clk);
        cs_rel = cs; dt_rel = dtack_n; be_rel = berr_n;
        @(negedge clk);
        busy_idle = busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; as_n = 1'b1; addr = '0;
        clear_table(); pack_table();
        repeat (2) @(negedge clk);
        n_checks++; if (cs !== '0)    $display("FAIL reset_cs got %h want 0", cs);       else n_pass++;
        n_checks++; if (dtack_n !== 1) $display("FAIL reset_dtack got %b want 1", dtack_n); else n_pass++;
        n_checks++; if (berr_n !== 1)  $display("FAIL reset_berr got %b want 1", berr_n);   else n_pass++;
        n_checks++; if (busy !== 0)    $display("FAIL reset_busy got %b want 0", busy);     else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int ack, be; logic [NR-1:0] c2, ca, cr; logic dt, bn, bi;
        clear_table();
        en_a[0] = 1; base_a[0] = 24'h000000; shift_a[0] = 17; wait_a[0] = 0;
        pack_table();
        run_cycle(24'h01FFFE, 10, 1'b0, ack, be, c2, ca);
        n_checks++; if (c2 !== 16'h0001) $display("FAIL r0_cs got %h want 0001", c2); else n_pass++;
        n_checks++; if (ack !== 3) $display("FAIL r0_latency got %0d want 3", ack); else n_pass++;
        release_cycle(cr, dt, bn, bi);

        clear_table();
        en_a[3] = 1; base_a[3] = 24'h044000; shift_a[3] = 1; wait_a[3] = 5;
        pack_table();
        run_cycle(24'h044001, 15, 1'b1, ack, be, c2, ca);
        n_checks++; if (c2 !== 16'h0008) $display("FAIL r3_cs got %h want 0008", c2); else n_pass++;
        n_checks++; if (ack !== 8) $display("FAIL r3_latency got %0d want 8", ack); else n_pass++;
        n_checks++; if (ca !== 16'h0008) $display("FAIL r3_cs_ack got %h want 0008", ca); else n_pass++;
        release_cycle(cr, dt, bn, bi);
        n_checks++; if (cr !== '0 || dt !== 1'b1) $display("FAIL r3_release got cs=%h dtack=%b want 0/1", cr, dt); else n_pass++;
        n_checks++; if (bi !== 1'b0) $display("FAIL r3_idle got busy=%b want 0", bi); else n_pass++;

        // Region 1 uses shift 14 so its window 0x040000-0x043FFF really covers 0x042010.
        clear_table();
        en_a[1] = 1; base_a[1] = 24'h040000; shift_a[1] = 14; wait_a[1] = 1;
        en_a[2] = 1; base_a[2] = 24'h042000; shift_a[2] = 12; wait_a[2] = 2;
        pack_table();
        run_cycle(24'h042010, 12, 1'b0, ack, be, c2, ca);
        n_checks++; if (c2 !== 16'h0002) $display("FAIL overlap_cs got %h want 0002", c2); else n_pass++;
        n_checks++; if (ack !== 4) $display("FAIL overlap_latency got %0d want 4", ack); else n_pass++;
        release_cycle(cr, dt, bn, bi);
        en_a[1] = 0; pack_table();
        run_cycle(24'h042010, 12, 1'b0, ack, be, c2, ca);
        n_checks++; if (c2 !== 16'h0004) $display("FAIL overlap_dis_cs got %h want 0004", c2); else n_pass++;
        n_checks++; if (ack !== 5) $display("FAIL overlap_dis_latency got %0d want 5", ack); else n_pass++;
        release_cycle(cr, dt, bn, bi);
    endtask

    task automatic test_nomatch();
        int ack, be; logic [NR-1:0] c2, ca, cr; logic dt, bn, bi;
        run_cycle(24'h0F0000, 2 + BC + 4, 1'b0, ack, be, c2, ca);
        n_checks++; if (c2 !== '0) $display("FAIL nomatch_cs got %h want 0", c2); else n_pass++;
        n_checks++; if (ack !== -1) $display("FAIL nomatch_dtack got edge %0d want none", ack); else n_pass++;
`ifdef BUS_DECODER_BERR_EN
        n_checks++; if (be !== 2 + BC) $display("FAIL nomatch_berr got edge %0d want %0d", be, 2 + BC); else n_pass++;
`else
        n_checks++; if (be !== -1) $display("FAIL nomatch_berr got edge %0d want none", be); else n_pass++;
`endif
        release_cycle(cr, dt, bn, bi);
        n_checks++; if (bn !== 1'b1 || cr !== '0) $display("FAIL nomatch_release got berr=%b cs=%h want 1/0", bn, cr); else n_pass++;
        n_checks++; if (bi !== 1'b0) $display("FAIL nomatch_idle got busy=%b want 0", bi); else n_pass++;
    endtask

    task automatic test_abort();
        int ack, be; logic [NR-1:0] c2, ca, cr; logic dt, bn, bi;
        clear_table();
        en_a[5] = 1; base_a[5] = 24'h300000; shift_a[5] = 16; wait_a[5] = 7;
        pack_table();
        run_cycle(24'h30ABCD, 4, 1'b0, ack, be, c2, ca);
        n_checks++; if (c2 !== 16'h0020) $display("FAIL abort_cs got %h want 0020", c2); else n_pass++;
        release_cycle(cr, dt, bn, bi);
        n_checks++; if (ack !== -1 || dt !== 1'b1) $display("FAIL abort_dtack got edge %0d dtack=%b want none/1", ack, dt); else n_pass++;
        n_checks++; if (cr !== '0) $display("FAIL abort_cs_clear got %h want 0", cr); else n_pass++;
        n_checks++; if (bi !== 1'b0) $display("FAIL abort_idle got busy=%b want 0", bi); else n_pass++;
        run_cycle(24'h30FFFF, 14, 1'b0, ack, be, c2, ca);
        n_checks++; if (ack !== 10) $display("FAIL abort_next_latency got %0d want 10", ack); else n_pass++;
        release_cycle(cr, dt, bn, bi);
    endtask

    task automatic test_reset_mid();
        int ack, be, ack2; logic [NR-1:0] c2, ca, cr; logic dt, bn, bi;
        clear_table();
        en_a[0] = 1; base_a[0] = 24'h000000; shift_a[0] = 17; wait_a[0] = 0;
        pack_table();
        run_cycle(24'h000100, 10, 1'b0, ack, be, c2, ca);
        n_checks++; if (ack !== 3) $display("FAIL rstmid_first_latency got %0d want 3", ack); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (cs !== '0) $display("FAIL rstmid_cs got %h want 0", cs); else n_pass++;
        n_checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_outs got dtack=%b busy=%b want 1/0", dtack_n, busy); else n_pass++;
        #1 reset_n = 1'b1;
        ack2 = -1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (dtack_n == 1'b0) begin ack2 = e; break; end
        end
        n_checks++; if (ack2 !== 3) $display("FAIL rstmid_restart_latency got %0d want 3", ack2); else n_pass++;
        n_checks++; if (cs !== 16'h0001) $display("FAIL rstmid_restart_cs got %h want 0001", cs); else n_pass++;
        release_cycle(cr, dt, bn, bi);
    endtask

    task automatic test_random();
        int ack, be, w, exp_ack, exp_be, sh; logic [NR-1:0] c2, ca, cr, ecs; logic dt, bn, bi;
        logic [AW-1:0] a;
        for (int t = 0; t < 40; t++) begin
            a = AW'($urandom);
            for (int i = 0; i < NR; i++) begin
                sh = ($urandom_range(0, 9) == 0) ? AW : int'($urandom_range(4, 23));
                shift_a[i] = sh;
                en_a[i]    = ($urandom_range(0, 1) == 1);
                wait_a[i]  = int'($urandom_range(0, 15));
                base_a[i]  = ($urandom_range(0, 3) == 0) ? (a ^ (AW'($urandom) >> (AW - sh)))
                                                         : AW'($urandom);
            end
            if (t % 5 == 0) for (int i = 0; i < NR; i++) en_a[i] = 1'b0;
            pack_table();
            ecs = model_cs(a, w);
            exp_ack = (ecs != '0) ? 3 + w : -1;
`ifdef BUS_DECODER_BERR_EN
            exp_be = (ecs == '0) ? 2 + BC : -1;
`else
            exp_be = -1;
`endif
            run_cycle(a, (ecs != '0) ? 3 + w + 2 : 2 + BC + 2, 1'b1, ack, be, c2, ca);
            n_checks++; if (c2 !== ecs) $display("FAIL rand%0d_cs addr=%h got %h want %h", t, a, c2, ecs); else n_pass++;
            n_checks++; if (ack !== exp_ack) $display("FAIL rand%0d_latency got %0d want %0d", t, ack, exp_ack); else n_pass++;
            n_checks++; if (be !== exp_be) $display("FAIL rand%0d_berr got %0d want %0d", t, be, exp_be); else n_pass++;
            if (ecs != '0) begin
                n_checks++; if (ca !== ecs) $display("FAIL rand%0d_cs_ack got %h want %h", t, ca, ecs); else n_pass++;
            end
            release_cycle(cr, dt, bn, bi);
            n_checks++; if (cr !== '0 || dt !== 1'b1 || bn !== 1'b1) $display("FAIL rand%0d_release got cs=%h dtack=%b berr=%b want 0/1/1", t, cr, dt, bn); else n_pass++;
            n_checks++; if (bi !== 1'b0) $display("FAIL rand%0d_idle got busy=%b want 0", t, bi); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_nomatch();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
